// File: rtl/boa_pmu_pkg.sv
// Shared definitions for the power-management unit: register map, unlock key, command and FSM encodings.
// No logic; constants and types only.
// Imported by boa_pmu_ctrl and boa_pmu_wdt.
package boa_pmu_pkg;

    // Register byte offsets (bus_addr[1:0] ignored)
    localparam logic [3:0] ADDR_CTRL       = 4'h0;
    localparam logic [3:0] ADDR_WDT_RELOAD = 4'h4;
    localparam logic [3:0] ADDR_WDT_COUNT  = 4'h8;
    localparam logic [3:0] ADDR_STATUS     = 4'hC;

    // Default unlock key expected in wdata[31:16] of CTRL / WDT_RELOAD writes
    localparam logic [15:0] PMU_KEY = 16'hB0A5;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_RST  = 2'd1,
        CMD_SHDN = 2'd2,
        CMD_KICK = 2'd3
    } pmu_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM_RST  = 3'd1,
        ST_ARM_SHDN = 3'd2,
        ST_FIRE_RST = 3'd3,
        ST_SHDN     = 3'd4
    } pmu_state_e;

endpackage

// File: rtl/boa_pmu_wdt.sv
// Watchdog down-counter: loads on reload/kick, decrements on tick while enabled and running.
// Latency: count updates on the clock edge after tick/reload; expire is combinational on the decrement to 0.
// No backpressure; a reload in the same cycle as a tick wins and suppresses the decrement.
module boa_pmu_wdt
    import boa_pmu_pkg::*;
#(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         run,
    input  logic         tick,
    input  logic         reload_en,
    input  logic [W-1:0] reload_val,
    output logic [W-1:0] count,
    output logic         expire
);

    logic dec;

    // A count already at zero stays there; expiry is the single 1 -> 0 step
    assign dec    = enable && run && tick && !reload_en && (count != '0);
    assign expire = dec && (count == W'(1));

    // Count register: reload has priority over decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (reload_en) begin
            count <= reload_val;
        end else if (dec) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/boa_pmu_ctrl.sv
// Power-management controller: keyed register interface, reset/poweroff sequencing FSM, watchdog.
// Latency: bus ack/rdata one cycle after bus_sel; accepted request -> pmu_rst/pmu_shdn after DELAY more cycles.
// Never stalls the bus: every access acks next cycle, unmapped or badly keyed writes are dropped.
module boa_pmu_ctrl
    import boa_pmu_pkg::*;
#(
    parameter int          DELAY = 16,
    parameter int          WDT_W = 24,
    parameter logic [15:0] KEY   = PMU_KEY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        bus_sel,
    input  logic        bus_we,
    input  logic [3:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        pmu_rst,
    output logic        pmu_shdn
);

    localparam int RL_W = (WDT_W < 16) ? WDT_W : 16;
    localparam int DCW  = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam logic [DCW-1:0] DLY_INIT = DCW'(DELAY - 1);

    pmu_state_e       state, state_next;
    logic [DCW-1:0]   dly_ctr;
    logic [WDT_W-1:0] reload_q, wr_reload, wdt_count, wdt_reload_val;
    logic             badkey, last_wdt, wdt_expire, wdt_reload_en;
    logic             armed, shdn_pending;
    logic [31:0]      rd_mux;
    logic [3:0]       reg_off;
    logic             key_ok, ctrl_wr, reload_wr, status_wr, ctrl_ok, reload_ok;
    logic             cmd_rst, cmd_shdn, cmd_kick, sw_taken, wdt_taken;
    pmu_cmd_e         cmd;
    logic             unused_addr_bits;

    // Bus decode
    assign unused_addr_bits = ^bus_addr[1:0];
    assign reg_off   = {bus_addr[3:2], 2'b00};
    assign key_ok    = (bus_wdata[31:16] == KEY);
    assign ctrl_wr   = bus_sel && bus_we && (reg_off == ADDR_CTRL);
    assign reload_wr = bus_sel && bus_we && (reg_off == ADDR_WDT_RELOAD);
    assign status_wr = bus_sel && bus_we && (reg_off == ADDR_STATUS);
    assign ctrl_ok   = ctrl_wr && key_ok;
    assign reload_ok = reload_wr && key_ok;
    assign cmd       = pmu_cmd_e'(bus_wdata[1:0]);
    assign cmd_rst   = ctrl_ok && (cmd == CMD_RST);
    assign cmd_shdn  = ctrl_ok && (cmd == CMD_SHDN);
    assign cmd_kick  = ctrl_ok && (cmd == CMD_KICK);
    assign wr_reload = WDT_W'(bus_wdata[RL_W-1:0]);

    // Which request the FSM actually accepts this cycle (software beats the watchdog)
    assign sw_taken  = ((state == ST_IDLE) && (cmd_rst || cmd_shdn)) ||
                       ((state == ST_ARM_RST) && cmd_shdn);
    assign wdt_taken = (state == ST_IDLE) && wdt_expire && !cmd_rst && !cmd_shdn;

    // Watchdog: a keyed reload write loads the new value, a kick reloads the stored one
    assign wdt_reload_en  = reload_ok || cmd_kick;
    assign wdt_reload_val = reload_ok ? wr_reload : reload_q;

    boa_pmu_wdt #(.W(WDT_W)) u_wdt (
        .clk        (clk),
        .rst        (rst),
        .enable     (reload_q != '0),
        .run        (state == ST_IDLE),
        .tick       (tick),
        .reload_en  (wdt_reload_en),
        .reload_val (wdt_reload_val),
        .count      (wdt_count),
        .expire     (wdt_expire)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next state: poweroff overrides a pending reset; reset requests never restart a countdown
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (cmd_shdn)                  state_next = ST_ARM_SHDN;
                else if (cmd_rst || wdt_expire) state_next = ST_ARM_RST;
            end
            ST_ARM_RST: begin
                if (cmd_shdn)             state_next = ST_ARM_SHDN;
                else if (dly_ctr == '0)   state_next = ST_FIRE_RST;
            end
            ST_ARM_SHDN: if (dly_ctr == '0) state_next = ST_SHDN;
            ST_FIRE_RST: state_next = ST_IDLE;
            ST_SHDN:     state_next = ST_SHDN;
            default:     state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pmu_rst      = (state == ST_FIRE_RST);
        pmu_shdn     = (state == ST_SHDN);
        armed        = (state == ST_ARM_RST) || (state == ST_ARM_SHDN);
        shdn_pending = (state == ST_ARM_SHDN) || (state == ST_SHDN);
    end

    // Delay counter: reloaded on every accepted transition into an ARM state
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_ctr <= '0;
        end else if ((state == ST_IDLE && state_next != ST_IDLE) ||
                     (state == ST_ARM_RST && state_next == ST_ARM_SHDN)) begin
            dly_ctr <= DLY_INIT;
        end else if (dly_ctr != '0) begin
            dly_ctr <= dly_ctr - DCW'(1);
        end
    end

    // Software-visible registers: reload value, sticky bad-key flag, request cause
    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
            badkey   <= 1'b0;
            last_wdt <= 1'b0;
        end else begin
            if (reload_ok)
                reload_q <= wr_reload;
            if ((ctrl_wr || reload_wr) && !key_ok)
                badkey <= 1'b1;
            else if (status_wr && bus_wdata[0])
                badkey <= 1'b0;
            if (sw_taken)
                last_wdt <= 1'b0;
            else if (wdt_taken)
                last_wdt <= 1'b1;
        end
    end

    // Read mux
    always_comb begin
        rd_mux = 32'd0;
        case (reg_off)
            ADDR_CTRL:       rd_mux = {30'd0, armed, shdn_pending};
            ADDR_WDT_RELOAD: rd_mux = 32'(reload_q);
            ADDR_WDT_COUNT:  rd_mux = 32'(wdt_count);
            ADDR_STATUS:     rd_mux = {29'd0, (reload_q != '0), last_wdt, badkey};
            default:         rd_mux = 32'd0;
        endcase
    end

    // Bus response: single-cycle ack, rdata only driven for reads
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ack   <= 1'b0;
            bus_rdata <= 32'd0;
        end else begin
            bus_ack   <= bus_sel;
            bus_rdata <= (bus_sel && !bus_we) ? rd_mux : 32'd0;
        end
    end

endmodule

// File: tb/tb_boa_pmu_ctrl.sv
// Self-checking bench for boa_pmu_ctrl: randomized register traffic checked against a behavioural model.
// Timing expectations are derived from the accept edge of each access plus DELAY.
// Inputs driven #1 after posedge; outputs sampled #1 after posedge or on negedge.
module tb_boa_pmu_ctrl;
    import boa_pmu_pkg::*;

    localparam int          DELAY = 16;
    localparam int          WDT_W = 24;
    localparam logic [15:0] KEY   = 16'hB0A5;

    logic        clk = 1'b0;
    logic        rst, tick, bus_sel, bus_we;
    logic [3:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ack, pmu_rst, pmu_shdn;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model of the software-visible state
    int unsigned m_reload;
    int unsigned m_count;
    bit          m_badkey;
    bit          m_last_wdt;

    // Event logs, indexed by number of rising edges seen
    int cyc = 0;
    int rst_log[$];
    int shdn_rise = -1;

    boa_pmu_ctrl #(.DELAY(DELAY), .WDT_W(WDT_W), .KEY(KEY)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .bus_sel   (bus_sel),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .pmu_rst   (pmu_rst),
        .pmu_shdn  (pmu_shdn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pmu_rst === 1'b1) rst_log.push_back(cyc);
        if (pmu_shdn === 1'b1 && shdn_rise < 0) shdn_rise = cyc;
    end

    function automatic logic [31:0] exp_status();
        return {29'd0, (m_reload != 0), m_last_wdt, m_badkey};
    endfunction

    function automatic int first_rst();
        return (rst_log.size() > 0) ? rst_log[0] : -1;
    endfunction

    // One bus access; returns the response seen one cycle later and the accept edge number
    task automatic bus_op(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic ak, output int acc);
        bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
        @(posedge clk); #1;
        acc = cyc; ak = bus_ack; rd = bus_rdata;
        bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick_once(output int acc);
        tick = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'd0;
        idle(2);
        rst = 1'b0;
        rst_log.delete();
        shdn_rise  = -1;
        m_reload   = 0; m_count = 0; m_badkey = 0; m_last_wdt = 0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ak; int p;
        logic [3:0] addrs [4] = '{4'h8, 4'hC, 4'h0, 4'h5};
        do_reset();
        n_checks++; if (pmu_rst !== 1'b0 || pmu_shdn !== 1'b0) $display("FAIL reset_outputs: rst=%b shdn=%b want 0 0", pmu_rst, pmu_shdn); else n_pass++;
        n_checks++; if (bus_ack !== 1'b0 || bus_rdata !== 32'd0) $display("FAIL reset_bus: ack=%b rdata=%h want 0 0", bus_ack, bus_rdata); else n_pass++;
        // Back-to-back reads: every one acks
        for (int i = 0; i < 4; i++) begin
            bus_op(1'b0, addrs[i], 32'd0, rd, ak, p);
            n_checks++; if (ak !== 1'b1 || rd !== 32'd0) $display("FAIL reset_read_%0h: ack=%b rdata=%h want 1 0", addrs[i], ak, rd); else n_pass++;
        end
        idle(1);
        n_checks++; if (bus_ack !== 1'b0) $display("FAIL ack_one_cycle: ack=%b want 0", bus_ack); else n_pass++;
    endtask

    task automatic test_ctrl_reset();
        logic [31:0] rd; logic ak; int p, p2;
        for (int it = 0; it < 3; it++) begin
            rst_log.delete();
            idle($urandom_range(0, 3));
            bus_op(1'b1, 4'h0, {KEY, 14'($urandom), 2'b01}, rd, ak, p);
            n_checks++; if (ak !== 1'b1) $display("FAIL ctrl_wr_ack%0d: ack=%b want 1", it, ak); else n_pass++;
            bus_op(1'b0, 4'h0, 32'd0, rd, ak, p2);
            n_checks++; if (rd !== 32'h2) $display("FAIL ctrl_armed%0d: rdata=%h want 2", it, rd); else n_pass++;
            if (it != 0) begin
                // A second reset request during the countdown must not restart it
                idle($urandom_range(1, 8));
                bus_op(1'b1, 4'h0, {KEY, 16'h0001}, rd, ak, p2);
            end
            idle(DELAY + 4);
            n_checks++; if (rst_log.size() != 1 || first_rst() != p + DELAY) $display("FAIL ctrl_rst_time%0d: pulses=%0d first=%0d want 1 at %0d", it, rst_log.size(), first_rst(), p + DELAY); else n_pass++;
            n_checks++; if (pmu_shdn !== 1'b0 || shdn_rise != -1) $display("FAIL ctrl_rst_noshdn%0d: shdn=%b rise=%0d want 0", it, pmu_shdn, shdn_rise); else n_pass++;
        end
        m_last_wdt = 0;
    endtask

    task automatic test_badkey();
        logic [31:0] rd; logic ak; int p;
        logic [15:0] k;
        k = 16'($urandom);
        if (k == KEY) k = k ^ 16'h0001;
        rst_log.delete();
        bus_op(1'b1, 4'h0, {k, 16'h0002}, rd, ak, p);
        m_badkey = 1;
        n_checks++; if (ak !== 1'b1) $display("FAIL badkey_ack: ack=%b want 1", ak); else n_pass++;
        idle(DELAY + 4);
        n_checks++; if (shdn_rise != -1 || rst_log.size() != 0) $display("FAIL badkey_noaction: shdn_rise=%0d pulses=%0d want -1 0", shdn_rise, rst_log.size()); else n_pass++;
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
        n_checks++; if (rd !== exp_status()) $display("FAIL badkey_status: got %h want %h", rd, exp_status()); else n_pass++;
        bus_op(1'b1, 4'h4, {k, 16'h0005}, rd, ak, p);
        bus_op(1'b0, 4'h4, 32'd0, rd, ak, p);
        n_checks++; if (rd !== 32'(m_reload)) $display("FAIL badkey_reload: got %h want %h", rd, m_reload); else n_pass++;
        bus_op(1'b1, 4'hC, {31'($urandom), 1'b0}, rd, ak, p);
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
        n_checks++; if (rd !== exp_status()) $display("FAIL badkey_noclear: got %h want %h", rd, exp_status()); else n_pass++;
        bus_op(1'b1, 4'hC, 32'd1, rd, ak, p);
        m_badkey = 0;
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
        n_checks++; if (rd !== exp_status()) $display("FAIL badkey_clear: got %h want %h", rd, exp_status()); else n_pass++;
    endtask

    task automatic test_wdt();
        logic [31:0] rd; logic ak; int p, t;
        int unsigned r;
        for (int it = 0; it < 2; it++) begin
            r = (it == 0) ? 3 : $urandom_range(2, 6);
            rst_log.delete();
            bus_op(1'b1, 4'h4, {KEY, 16'(r)}, rd, ak, p);
            m_reload = r; m_count = r;
            bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
            n_checks++; if (rd !== 32'(m_count)) $display("FAIL wdt_load%0d: count=%0d want %0d", it, rd, m_count); else n_pass++;
            bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
            n_checks++; if (rd !== exp_status()) $display("FAIL wdt_status_en%0d: got %h want %h", it, rd, exp_status()); else n_pass++;
            for (int k = 1; k < int'(r); k++) begin
                tick_once(t);
                m_count--;
                bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
                n_checks++; if (rd !== 32'(m_count)) $display("FAIL wdt_dec%0d_%0d: count=%0d want %0d", it, k, rd, m_count); else n_pass++;
            end
            // Kick alone, then kick together with a tick: both leave the full reload
            bus_op(1'b1, 4'h0, {KEY, 16'h0003}, rd, ak, p);
            m_count = r;
            tick = 1'b1;
            bus_op(1'b1, 4'h0, {KEY, 16'h0003}, rd, ak, p);
            tick = 1'b0;
            bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
            n_checks++; if (rd !== 32'(m_count)) $display("FAIL wdt_kick%0d: count=%0d want %0d", it, rd, m_count); else n_pass++;
            n_checks++; if (rst_log.size() != 0) $display("FAIL wdt_kick_norst%0d: pulses=%0d want 0", it, rst_log.size()); else n_pass++;
            for (int k = 1; k <= int'(r); k++) begin
                tick_once(t);
                m_count--;
                bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
                n_checks++; if (rd !== 32'(m_count)) $display("FAIL wdt_run%0d_%0d: count=%0d want %0d", it, k, rd, m_count); else n_pass++;
            end
            m_last_wdt = 1;
            idle(DELAY + 3);
            n_checks++; if (rst_log.size() != 1 || first_rst() != t + DELAY) $display("FAIL wdt_expire%0d: pulses=%0d first=%0d want 1 at %0d", it, rst_log.size(), first_rst(), t + DELAY); else n_pass++;
            bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
            n_checks++; if (rd !== exp_status()) $display("FAIL wdt_cause%0d: got %h want %h", it, rd, exp_status()); else n_pass++;
            // Ticks at zero neither wrap nor expire again
            tick_once(t);
            idle(DELAY + 3);
            bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
            n_checks++; if (rd !== 32'd0 || rst_log.size() != 1) $display("FAIL wdt_zero%0d: count=%0d pulses=%0d want 0 1", it, rd, rst_log.size()); else n_pass++;
        end
        bus_op(1'b1, 4'h4, {KEY, 16'h0000}, rd, ak, p);
        m_reload = 0; m_count = 0;
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
        n_checks++; if (rd !== exp_status()) $display("FAIL wdt_disable: got %h want %h", rd, exp_status()); else n_pass++;
    endtask

    task automatic test_collision();
        logic [31:0] rd; logic ak; int p;
        // Expiry and software reset in the same cycle: one pulse, software cause
        rst_log.delete();
        bus_op(1'b1, 4'h4, {KEY, 16'h0001}, rd, ak, p);
        m_reload = 1; m_count = 1;
        tick = 1'b1;
        bus_op(1'b1, 4'h0, {KEY, 16'h0001}, rd, ak, p);
        tick = 1'b0;
        m_count = 0; m_last_wdt = 0;
        idle(DELAY + 3);
        n_checks++; if (rst_log.size() != 1 || first_rst() != p + DELAY) $display("FAIL coll_rst: pulses=%0d first=%0d want 1 at %0d", rst_log.size(), first_rst(), p + DELAY); else n_pass++;
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, p);
        n_checks++; if (rd !== exp_status()) $display("FAIL coll_cause: got %h want %h", rd, exp_status()); else n_pass++;
        bus_op(1'b0, 4'h8, 32'd0, rd, ak, p);
        n_checks++; if (rd !== 32'(m_count)) $display("FAIL coll_count: got %0d want %0d", rd, m_count); else n_pass++;
        // Expiry and poweroff in the same cycle: poweroff only
        rst_log.delete();
        bus_op(1'b1, 4'h4, {KEY, 16'h0001}, rd, ak, p);
        tick = 1'b1;
        bus_op(1'b1, 4'h0, {KEY, 16'h0002}, rd, ak, p);
        tick = 1'b0;
        idle(DELAY + 6);
        n_checks++; if (shdn_rise != p + DELAY || rst_log.size() != 0) $display("FAIL coll_shdn: rise=%0d pulses=%0d want %0d 0", shdn_rise, rst_log.size(), p + DELAY); else n_pass++;
        do_reset();
        n_checks++; if (pmu_shdn !== 1'b0) $display("FAIL coll_shdn_clear: shdn=%b want 0", pmu_shdn); else n_pass++;
    endtask

    task automatic test_shdn();
        logic [31:0] rd; logic ak; int p1, p2;
        rst_log.delete();
        bus_op(1'b1, 4'h0, {KEY, 16'h0001}, rd, ak, p1);
        idle($urandom_range(2, 10));
        bus_op(1'b1, 4'h0, {KEY, 16'h0002}, rd, ak, p2);
        idle(DELAY + 20);
        n_checks++; if (rst_log.size() != 0) $display("FAIL shdn_norst: pulses=%0d want 0 (first reset write at %0d)", rst_log.size(), p1); else n_pass++;
        n_checks++; if (shdn_rise != p2 + DELAY) $display("FAIL shdn_time: rise=%0d want %0d", shdn_rise, p2 + DELAY); else n_pass++;
        bus_op(1'b1, 4'h0, {KEY, 16'h0001}, rd, ak, p1);
        idle(DELAY + 4);
        bus_op(1'b0, 4'h0, 32'd0, rd, ak, p1);
        n_checks++; if (rd !== 32'h1 || pmu_shdn !== 1'b1 || rst_log.size() != 0) $display("FAIL shdn_hold: ctrl=%h shdn=%b pulses=%0d want 1 1 0", rd, pmu_shdn, rst_log.size()); else n_pass++;
        do_reset();
        n_checks++; if (pmu_shdn !== 1'b0) $display("FAIL shdn_reset: shdn=%b want 0", pmu_shdn); else n_pass++;
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd; logic ak; int p, q;
        bus_op(1'b1, 4'h4, {KEY, 16'($urandom_range(1, 16'hFFFF))}, rd, ak, q);
        rst_log.delete();
        bus_op(1'b1, 4'h0, {KEY, 16'h0001}, rd, ak, p);
        idle(DELAY - 5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_reload = 0; m_count = 0; m_badkey = 0; m_last_wdt = 0;
        idle(DELAY + 4);
        n_checks++; if (rst_log.size() != 0) $display("FAIL rstmid_nopulse: pulses=%0d want 0 (request at %0d)", rst_log.size(), p); else n_pass++;
        bus_op(1'b0, 4'h0, 32'd0, rd, ak, q);
        n_checks++; if (rd !== 32'd0) $display("FAIL rstmid_idle: ctrl=%h want 0", rd); else n_pass++;
        bus_op(1'b0, 4'hC, 32'd0, rd, ak, q);
        n_checks++; if (rd !== exp_status()) $display("FAIL rstmid_status: got %h want %h", rd, exp_status()); else n_pass++;
        bus_op(1'b0, 4'h8, 32'd0, rd, ak, q);
        n_checks++; if (rd !== 32'(m_count)) $display("FAIL rstmid_count: got %0d want %0d", rd, m_count); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'd0;
        #1;
        test_reset();
        test_ctrl_reset();
        test_badkey();
        test_wdt();
        test_collision();
        test_shdn();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
